// File: rtl/apb_master_nslv.sv
// APB4 requester bridging a simple transfer/ready request port onto NUM_SLV slaves,
// with address-map checking, PSLVERR propagation, byte strobes and a wait-state timeout.
module apb_master_nslv #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                SPAN_LOG2   = 12,
  parameter int                TIMEOUT_CYC = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic                      busy,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      slverr
);

  // state  | meaning
  // IDLE   | waiting for a request
  // SETUP  | PSEL asserted, PENABLE low, one cycle
  // ACCESS | PSEL and PENABLE asserted, waiting for PREADY or timeout
  // ERR    | unmapped address, no bus activity, one cycle

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [ADDR_W:0]   WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   WIN_HI    = WIN_LO + ((ADDR_W+1)'(NUM_SLV) << SPAN_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDX_W-1:0]  sel_idx;
  logic              addr_mapped;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;

  // Window math is one bit wider so a window ending at the top of memory cannot wrap.
  assign addr_mapped = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
  assign sel_idx     = (NUM_SLV > 1) ? PADDR[SPAN_LOG2 +: IDX_W] : '0;
  assign sel_ready   = PREADY[sel_idx];
  assign sel_err     = PSLVERR[sel_idx];
  assign sel_rdata   = PRDATA[sel_idx*DATA_W +: DATA_W];
  assign cnt_inc     = wait_cnt + 1'b1;

  always_comb begin
    PSEL = '0;
    if (state == S_SETUP || state == S_ACCESS) PSEL[sel_idx] = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PENABLE  <= 1'b0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rdata    <= '0;
      slverr   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (transfer) begin
            PADDR    <= addr;
            PWRITE   <= write;
            PWDATA   <= wdata;
            PSTRB    <= write ? wstrb : '0;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= addr_mapped ? S_SETUP : S_ERR;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (sel_ready) begin
            if (!PWRITE) rdata <= sel_rdata;
            slverr  <= sel_err;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (TIMEOUT_CYC != 0 && cnt_inc == CNT_LIMIT) begin
            slverr  <= 1'b1;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        S_ERR: begin
          slverr <= 1'b1;
          ready  <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
